layer_sched: RTL
================

// Module: layer_sched
// PURPOSE
//  Sequences the FP/BP/WG phase FSM across a multi-layer training step. Holds a per-layer stride
//  table, launches one phase-FSM run per layer and waits for it to return to IDLE before the next.
//  Sits between the host/top-level control and the phase FSM (drives its in/stride, reads curr_state).
// PARAMETERS
//  MAX_LAYERS  8    depth of stride table, max layers per step
//  LAYER_W     3    index width, clog2(MAX_LAYERS)
//  LAUNCH_TO   16   cycles allowed for phase FSM to leave IDLE after launch
//  WD_CYCLES   255  watchdog: max cycles for one layer run (launch to return to IDLE)
//  PERF_W      16   width of per-layer cycle counter (saturating)
// PORTS
//  clk          in   1          clock
//  sched_rst_n  in   1          async reset, active low
//  start        in   1          step start pulse; sampled only in S_IDLE
//  abort        in   1          abort current step; any state -> S_IDLE next cycle
//  num_layers   in   LAYER_W+1  layers in step; latched on accepted start
//  cfg_we       in   1          stride table write; ignored while busy=1
//  cfg_addr     in   LAYER_W    table entry
//  cfg_stride   in   1          0 = stride 1, 1 = stride 2
//  fsm_state    in   3          phase FSM curr_state (0 = IDLE)
//  fsm_in       out  1          phase FSM start, one-cycle pulse
//  fsm_stride   out  1          stride to phase FSM, stable from launch until layer returns to IDLE
//  layer_idx    out  LAYER_W    layer currently being run
//  busy         out  1          high from accepted start until S_DONE/S_ERR/abort
//  done         out  1          one-cycle pulse, step completed
//  err          out  1          sticky; cleared by accepted start or reset
//  layer_cycles out  PERF_W     cycles of last completed layer run, saturating
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, stride table all 0, counters 0.
//  States: S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_IDLE, S_NEXT, S_DONE, S_ERR.
//  S_IDLE: start & num_layers==0 -> S_DONE (no launch). start & num_layers>MAX_LAYERS -> S_ERR.
//    start otherwise -> latch num_layers, layer_idx=0, err=0, busy=1, -> S_LAUNCH.
//  S_LAUNCH: fsm_in=1 for exactly this cycle; fsm_stride=table[layer_idx] registered here; clear
//    run counters -> S_WAIT_BUSY.
//  S_WAIT_BUSY: fsm_state!=0 -> S_WAIT_IDLE. LAUNCH_TO cycles elapsed with fsm_state==0 -> S_ERR.
//  S_WAIT_IDLE: fsm_state==0 -> S_NEXT, layer_cycles<=run count. Run count reaches WD_CYCLES -> S_ERR.
//  S_NEXT: layer_idx==num_layers-1 -> S_DONE; else layer_idx+1 -> S_LAUNCH.
//  S_DONE: done=1 one cycle, busy=0 -> S_IDLE. S_ERR: err=1, busy=0 -> S_IDLE.
//  Run count: increments every cycle from S_LAUNCH through S_WAIT_IDLE; saturates at 2^PERF_W-1.
//  Launch-to-launch latency: fsm_in pulses never closer than 3 cycles; fsm_in never high unless
//    fsm_state==0 in the same cycle.
//  cfg_we with busy=0 writes next edge; same-cycle cfg_we and start: write lands, start uses new value.
//  abort: highest priority; fsm_in forced 0 that cycle, busy=0, no done, err unchanged; phase FSM
//    not reset by this block. start in same cycle as abort is ignored.
//  start while busy: ignored. Reset mid-step: immediate return to reset values.
// TESTING
//  T1 table={0,1,0}, num_layers=3, model FSM busy 20 cyc -> 3 fsm_in pulses, fsm_stride 0,1,0, done once, layer_cycles=22.
//  T2 num_layers=0 start -> done 1 cycle later, no fsm_in, busy stays 0 after.
//  T3 model never leaves IDLE -> err=1 after LAUNCH_TO=16 cycles, busy=0, no done.
//  T4 model stuck non-IDLE -> err at WD_CYCLES=255; next start clears err and runs normally.
//  T5 abort during layer 1 of 4 -> busy=0 next cycle, no further fsm_in, no done; cfg_we during busy ignored.
//  T6 num_layers=9 (MAX_LAYERS=8) -> err=1, no fsm_in; sched_rst_n low mid-step -> all outputs 0.

Source files
------------

// File: rtl/layer_sched.sv
// Multi-layer step sequencer: walks a per-layer stride table and launches one
// phase-FSM run per layer, with launch timeout, run watchdog and per-layer cycle count.
module layer_sched #(
  parameter int MAX_LAYERS = 8,
  parameter int LAYER_W    = 3,
  parameter int LAUNCH_TO  = 16,
  parameter int WD_CYCLES  = 255,
  parameter int PERF_W     = 16
) (
  input  logic               clk,
  input  logic               sched_rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W:0]   num_layers,
  input  logic               cfg_we,
  input  logic [LAYER_W-1:0] cfg_addr,
  input  logic               cfg_stride,
  input  logic [2:0]         fsm_state,
  output logic               fsm_in,
  output logic               fsm_stride,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [PERF_W-1:0]  layer_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_IDLE, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam int TO_W = $clog2(LAUNCH_TO + 1);
  localparam logic [LAYER_W:0]   MAX_L   = (LAYER_W+1)'(MAX_LAYERS);
  localparam logic [LAYER_W:0]   ONE_L   = (LAYER_W+1)'(1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(LAUNCH_TO - 1);
  localparam logic [TO_W-1:0]    ONE_TO  = TO_W'(1);
  localparam logic [PERF_W-1:0]  WD_LIM  = PERF_W'(WD_CYCLES);
  localparam logic [PERF_W-1:0]  ONE_P   = PERF_W'(1);
  localparam logic [LAYER_W-1:0] ONE_IDX = LAYER_W'(1);

  state_t             state_reg, state_next;
  logic               table_reg [MAX_LAYERS];
  logic [LAYER_W:0]   num_reg;
  logic [LAYER_W-1:0] idx_reg, idx_next;
  logic               stride_reg, err_reg;
  logic [PERF_W-1:0]  run_cnt_reg, run_inc, cycles_reg;
  logic [TO_W-1:0]    to_cnt_reg;
  logic               cfg_wr, fsm_idle, is_last, enter_launch, stride_sel;

  assign fsm_idle     = (fsm_state == 3'd0);
  assign cfg_wr       = cfg_we & ~busy;
  assign run_inc      = (&run_cnt_reg) ? run_cnt_reg : run_cnt_reg + ONE_P;
  assign is_last      = ({1'b0, idx_reg} == num_reg - ONE_L);
  assign enter_launch = (state_next == S_LAUNCH) && (state_reg != S_LAUNCH);
  // A table write in the same cycle as the launch must be seen by that launch.
  assign stride_sel   = (cfg_wr && cfg_addr == idx_next) ? cfg_stride : table_reg[idx_next];

  generate
    for (genvar gi = 0; gi < MAX_LAYERS; gi++) begin : g_table
      always_ff @(posedge clk or negedge sched_rst_n) begin
        if (!sched_rst_n)
          table_reg[gi] <= 1'b0;
        else if (cfg_wr && cfg_addr == LAYER_W'(gi))
          table_reg[gi] <= cfg_stride;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge sched_rst_n) begin
    if (!sched_rst_n) state_reg <= S_IDLE;
    else              state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          if (num_layers == '0)        state_next = S_DONE;
          else if (num_layers > MAX_L) state_next = S_ERR;
          else begin
            state_next = S_LAUNCH;
            idx_next   = '0;
          end
        end
        // Hold off the launch until the phase FSM is back in IDLE (e.g. after an abort).
        S_LAUNCH:    if (fsm_idle) state_next = S_WAIT_BUSY;
        S_WAIT_BUSY: if (!fsm_idle) state_next = S_WAIT_IDLE;
                     else if (to_cnt_reg == TO_LAST) state_next = S_ERR;
        S_WAIT_IDLE: if (fsm_idle) state_next = S_NEXT;
                     else if (run_inc >= WD_LIM) state_next = S_ERR;
        S_NEXT: if (is_last) state_next = S_DONE;
                else begin
                  state_next = S_LAUNCH;
                  idx_next   = idx_reg + ONE_IDX;
                end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fsm_in = (state_reg == S_LAUNCH) && fsm_idle && !abort;
    busy   = (state_reg == S_LAUNCH) || (state_reg == S_WAIT_BUSY) ||
             (state_reg == S_WAIT_IDLE) || (state_reg == S_NEXT);
    done   = (state_reg == S_DONE) && !abort;
  end

  always_ff @(posedge clk or negedge sched_rst_n) begin
    if (!sched_rst_n) begin
      num_reg     <= '0;
      idx_reg     <= '0;
      stride_reg  <= 1'b0;
      err_reg     <= 1'b0;
      run_cnt_reg <= '0;
      cycles_reg  <= '0;
      to_cnt_reg  <= '0;
    end else begin
      idx_reg <= idx_next;
      if (enter_launch) stride_reg <= stride_sel;
      if (state_reg == S_IDLE && start && !abort) begin
        num_reg <= num_layers;
        err_reg <= 1'b0;
      end
      if (state_next == S_ERR) err_reg <= 1'b1;
      case (state_reg)
        S_LAUNCH: begin
          run_cnt_reg <= ONE_P;
          to_cnt_reg  <= '0;
        end
        S_WAIT_BUSY: begin
          run_cnt_reg <= run_inc;
          to_cnt_reg  <= to_cnt_reg + ONE_TO;
        end
        S_WAIT_IDLE: begin
          run_cnt_reg <= run_inc;
          if (fsm_idle && !abort) cycles_reg <= run_inc;
        end
        default: ;
      endcase
    end
  end

  assign fsm_stride   = stride_reg;
  assign layer_idx    = idx_reg;
  assign err          = err_reg;
  assign layer_cycles = cycles_reg;

endmodule
